// File: rtl/dlx_pkg.sv
// Shared writeback-stage definitions: result kinds, FIFO geometry, entry layout.
package dlx_pkg;

    // Encoding of the MEM-stage result kind presented on in_kind.
    typedef enum logic [2:0] {
        KIND_ALU  = 3'd0,
        KIND_LB   = 3'd1,
        KIND_LBU  = 3'd2,
        KIND_LH   = 3'd3,
        KIND_LHU  = 3'd4,
        KIND_LW   = 3'd5,
        KIND_JAL  = 3'd6,
        KIND_NONE = 3'd7
    } kind_e;

    localparam int FIFO_DEPTH = 2;
    localparam int RETIRE_W   = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // One buffered writeback: write intents are resolved at push time and
    // data already holds the final aligned/extended value (or link address).
    typedef struct packed {
        logic        wr_reg;
        logic        wr_r31;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // ALU results and every load flavour target the general register file.
    function automatic logic kind_writes_reg(kind_e kind);
        return kind inside {KIND_ALU, KIND_LB, KIND_LBU, KIND_LH, KIND_LHU, KIND_LW};
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian load extraction: selects byte/halfword by offset and extends it.
module load_align
    import dlx_pkg::*;
(
    input  kind_e       kind,
    input  logic [31:0] mem_data,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword and apply sign or zero extension.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        byte_sel  = mem_data[31:24];
        half_sel  = addr_lo[1] ? mem_data[15:0] : mem_data[31:16];
        load_data = mem_data;
        case (addr_lo)
            2'd0:    byte_sel = mem_data[31:24];
            2'd1:    byte_sel = mem_data[23:16];
            2'd2:    byte_sel = mem_data[15:8];
            default: byte_sel = mem_data[7:0];
        endcase
        case (kind)
            KIND_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            KIND_LBU: load_data = {24'd0, byte_sel};
            KIND_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            KIND_LHU: load_data = {16'd0, half_sel};
            default:  load_data = mem_data;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: 2-entry result buffer feeding registered register-file and
// link-register write ports, with a retirement counter.
// Optional head forwarding outputs are enabled by defining REGFILE_WB_FORWARD_EN.
module regfile_writeback
    import dlx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_rd,
    input  logic [2:0]          in_kind,
    input  logic [31:0]         in_result,
    input  logic [31:0]         in_mem_data,
    input  logic [1:0]          in_addr_lo,
    input  logic [31:0]         in_link,
    input  logic                hold,
    output logic                writenable,
    output logic [4:0]          writesel,
    output logic [31:0]         Din,
    output logic                r31_en,
    output logic [31:0]         register31,
    output logic [RETIRE_W-1:0] retire_count
`ifdef REGFILE_WB_FORWARD_EN
    ,
    output logic                fwd_valid,
    output logic [4:0]          fwd_rd,
    output logic [31:0]         fwd_data
`endif
);

    kind_e       in_kind_e;
    logic [31:0] load_data;
    wb_entry_t   in_entry;
    wb_entry_t   head;
    wb_entry_t   src;

    wb_entry_t   mem_q [FIFO_DEPTH];
    wb_entry_t   mem_d [FIFO_DEPTH];

    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                writenable_q, writenable_d;
    logic [4:0]          writesel_q, writesel_d;
    logic [31:0]         din_q, din_d;
    logic                r31_en_q, r31_en_d;
    logic [31:0]         register31_q, register31_d;
    logic [RETIRE_W-1:0] retire_count_q, retire_count_d;

    logic push, pop, bypass, store, retire, have_head;

    assign in_kind_e = kind_e'(in_kind);

    load_align u_load_align (
        .kind      (in_kind_e),
        .mem_data  (in_mem_data),
        .addr_lo   (in_addr_lo),
        .load_data (load_data)
    );

    // Build the buffered entry from the incoming MEM-stage result.
    always_comb begin
        in_entry        = '0;
        in_entry.rd     = in_rd;
        in_entry.wr_reg = kind_writes_reg(in_kind_e) && (in_rd != 5'd0);
        in_entry.wr_r31 = (in_kind_e == KIND_JAL);
        case (in_kind_e)
            KIND_ALU:  in_entry.data = in_result;
            KIND_JAL:  in_entry.data = in_link;
            KIND_NONE: in_entry.data = '0;
            default:   in_entry.data = load_data;
        endcase
    end

    // Handshake, pop/bypass decisions and next state of FIFO and write ports.
    // An entry arriving into an empty, un-held buffer skips storage so its
    // write lands on the very next cycle.
    always_comb begin
        in_ready  = (count_q < CNT_W'(FIFO_DEPTH));
        have_head = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        push      = in_valid && in_ready;
        pop       = have_head && !hold;
        bypass    = !have_head && push && !hold;
        store     = push && !bypass;
        retire    = pop || bypass;
        src       = have_head ? head : in_entry;

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = in_entry;
        end
        count_d  = count_q + CNT_W'(store) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(store);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        writenable_d   = retire && src.wr_reg;
        writesel_d     = (retire && src.wr_reg) ? src.rd : writesel_q;
        din_d          = (retire && src.wr_reg) ? src.data : din_q;
        r31_en_d       = retire && src.wr_r31;
        register31_d   = (retire && src.wr_r31) ? src.data : register31_q;
        retire_count_d = retire_count_q + RETIRE_W'(retire);
    end

    // Control state and registered write ports, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            writenable_q   <= 1'b0;
            writesel_q     <= '0;
            din_q          <= '0;
            r31_en_q       <= 1'b0;
            register31_q   <= '0;
            retire_count_q <= '0;
        end else begin
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            writenable_q   <= writenable_d;
            writesel_q     <= writesel_d;
            din_q          <= din_d;
            r31_en_q       <= r31_en_d;
            register31_q   <= register31_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Entry storage; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale slots are unreachable once count_q is cleared.
        mem_q <= mem_d;
    end

    assign writenable   = writenable_q;
    assign writesel     = writesel_q;
    assign Din          = din_q;
    assign r31_en       = r31_en_q;
    assign register31   = register31_q;
    assign retire_count = retire_count_q;

`ifdef REGFILE_WB_FORWARD_EN
    // Expose the buffer head so earlier stages can bypass pending writes.
    always_comb begin
        fwd_valid = have_head && (head.wr_reg || head.wr_r31);
        fwd_rd    = head.wr_r31 ? 5'd31 : head.rd;
        fwd_data  = head.data;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever a retirement is presented.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [2:0]  in_kind = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_mem_data = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_link = '0;
    logic        hold = 1'b0;
    logic        writenable;
    logic [4:0]  writesel;
    logic [31:0] Din;
    logic        r31_en;
    logic [31:0] register31;
    logic [15:0] retire_count;

    typedef struct {
        bit        we;
        bit [4:0]  sel;
        bit [31:0] din;
        bit        r31;
        bit [31:0] link;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] exp_retire = '0;
    logic [15:0] last_rc = '0;
    int          checks = 0;
    int          failures = 0;

    regfile_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_kind      (in_kind),
        .in_result    (in_result),
        .in_mem_data  (in_mem_data),
        .in_addr_lo   (in_addr_lo),
        .in_link      (in_link),
        .hold         (hold),
        .writenable   (writenable),
        .writesel     (writesel),
        .Din          (Din),
        .r31_en       (r31_en),
        .register31   (register31),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written straight from the kind rules.
    function automatic exp_t model(input logic [2:0] kind, input logic [4:0] rd,
                                   input logic [31:0] res, input logic [31:0] mem,
                                   input logic [1:0] lo, input logic [31:0] link);
        exp_t        e;
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(lo);
        b = 8'(mem >> (8 * (3 - off)));
        h = 16'(mem >> (16 * (1 - (off / 2))));
        e.we   = (kind <= 3'd5) && (rd != 5'd0);
        e.sel  = rd;
        e.r31  = (kind == 3'd6);
        e.link = link;
        case (kind)
            3'd0:    e.din = res;
            3'd1:    e.din = {{24{b[7]}}, b};
            3'd2:    e.din = {24'd0, b};
            3'd3:    e.din = {{16{h[15]}}, h};
            3'd4:    e.din = {16'd0, h};
            3'd5:    e.din = mem;
            default: e.din = '0;
        endcase
        return e;
    endfunction

    // Monitor: a change of retire_count marks one retired entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (retire_count !== last_rc) begin
                exp_retire = exp_retire + 16'd1;
                if (sb_q.size() == 0) begin
                    check("mon_unexpected_retire", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("mon_writenable", 32'(writenable), 32'(mon_e.we));
                    if (mon_e.we) begin
                        check("mon_writesel", 32'(writesel), 32'(mon_e.sel));
                        check("mon_din", Din, mon_e.din);
                    end
                    check("mon_r31_en", 32'(r31_en), 32'(mon_e.r31));
                    if (mon_e.r31) begin
                        check("mon_register31", register31, mon_e.link);
                    end
                    check("mon_retire_count", 32'(retire_count), 32'(exp_retire));
                end
            end else if (writenable || r31_en) begin
                check("mon_write_without_retire", {30'd0, writenable, r31_en}, 32'd0);
            end
        end
        last_rc = retire_count;
    end

    task automatic do_reset();
        in_valid = 1'b0;
        hold = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        exp_retire = '0;
        last_rc = '0;
    endtask

    task automatic push_entry(input logic [2:0] kind, input logic [4:0] rd,
                              input logic [31:0] res, input logic [31:0] mem,
                              input logic [1:0] lo, input logic [31:0] link,
                              input bit expect_it);
        int waited;
        in_valid = 1'b1;
        in_kind = kind;
        in_rd = rd;
        in_result = res;
        in_mem_data = mem;
        in_addr_lo = lo;
        in_link = link;
        waited = 0;
        while (!in_ready && waited < 20) begin
            hold = 1'b0;
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (expect_it) sb_q.push_back(model(kind, rd, res, mem, lo, link));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        hold = 1'b0;
        in_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_rc = '0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_writenable", 32'(writenable), 32'd0);
        check("rst_writesel", 32'(writesel), 32'd0);
        check("rst_din", Din, 32'd0);
        check("rst_r31_en", 32'(r31_en), 32'd0);
        check("rst_register31", register31, 32'd0);
        check("rst_retire_count", 32'(retire_count), 32'd0);

        // ALU write lands one cycle after acceptance.
        push_entry(3'd0, 5'd5, 32'h12345678, 32'h0, 2'd0, 32'h0, 1'b1);
        check("alu_latency_writenable", 32'(writenable), 32'd1);
        check("alu_latency_writesel", 32'(writesel), 32'd5);
        check("alu_latency_din", Din, 32'h12345678);
        check("alu_latency_retire", 32'(retire_count), 32'd1);

        // Byte loads at every offset, then an unsigned halfword.
        for (int i = 0; i < 4; i++) begin
            push_entry(3'd1, 5'd9, 32'h0, 32'h80FF7F01, 2'(i), 32'h0, 1'b1);
        end
        push_entry(3'd4, 5'd10, 32'h0, 32'h80FF7F01, 2'd2, 32'h0, 1'b1);
        drain();

        // JAL with rd 0 writes only the link register; ALU to r0 writes nothing.
        push_entry(3'd6, 5'd0, 32'h0, 32'h0, 2'd0, 32'h00000104, 1'b1);
        check("jal_r31_en", 32'(r31_en), 32'd1);
        check("jal_register31", register31, 32'h00000104);
        check("jal_writenable", 32'(writenable), 32'd0);
        push_entry(3'd0, 5'd0, 32'hDEADBEEF, 32'h0, 2'd0, 32'h0, 1'b1);
        check("alu_r0_writenable", 32'(writenable), 32'd0);
        drain();

        // Hold fills the buffer; release drains in order and admits the third.
        hold = 1'b1;
        push_entry(3'd0, 5'd1, 32'hA1A1A1A1, 32'h0, 2'd0, 32'h0, 1'b1);
        push_entry(3'd0, 5'd2, 32'hB2B2B2B2, 32'h0, 2'd0, 32'h0, 1'b1);
        in_valid = 1'b1;
        in_kind = 3'd0;
        in_rd = 5'd3;
        in_result = 32'hC3C3C3C3;
        repeat (2) begin
            check("hold_full_in_ready", 32'(in_ready), 32'd0);
            check("hold_no_write", 32'(writenable), 32'd0);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(posedge clk); #1;
        check("hold_first_sel", 32'(writesel), 32'd1);
        check("hold_first_din", Din, 32'hA1A1A1A1);
        check("hold_third_ready", 32'(in_ready), 32'd1);
        sb_q.push_back(model(3'd0, 5'd3, 32'hC3C3C3C3, 32'h0, 2'd0, 32'h0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_second_we", 32'(writenable), 32'd1);
        check("hold_second_sel", 32'(writesel), 32'd2);
        check("hold_second_din", Din, 32'hB2B2B2B2);
        @(posedge clk); #1;
        check("hold_third_sel", 32'(writesel), 32'd3);
        check("hold_third_din", Din, 32'hC3C3C3C3);
        drain();

        // Reset with two queued entries discards them.
        hold = 1'b1;
        push_entry(3'd0, 5'd7, 32'h77777777, 32'h0, 2'd0, 32'h0, 1'b0);
        push_entry(3'd5, 5'd8, 32'h0, 32'h88888888, 2'd0, 32'h0, 1'b0);
        check("rst_mid_full", 32'(in_ready), 32'd0);
        do_reset();
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_retire", 32'(retire_count), 32'd0);
        check("rst_mid_writenable", 32'(writenable), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_retire_after", 32'(retire_count), 32'd0);

        // Randomized traffic with random hold and idle gaps.
        for (int i = 0; i < 300; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            push_entry(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom(),
                       $urandom(), 2'($urandom_range(0, 3)), $urandom(), 1'b1);
        end
        drain();

        // Counter wrap: 65535 retirements, then one more.
        do_reset();
        in_valid = 1'b1;
        in_kind = 3'd7;
        in_rd = 5'd0;
        for (int i = 0; i < 65535; i++) begin
            sb_q.push_back(model(3'd7, 5'd0, 32'h0, 32'h0, 2'd0, 32'h0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("wrap_preset", 32'(retire_count), 32'h0000FFFF);
        push_entry(3'd0, 5'd0, 32'h1, 32'h0, 2'd0, 32'h0, 1'b1);
        check("wrap_to_zero", 32'(retire_count), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
